pushbutton_toggle: RTL and testbench

- Conditions the two board pushbuttons SW1/SW2 and turns each clean press into a one-cycle event plus a latched toggle that drives LED0/LED1.
- Sits between the raw pad inputs and any logic or LEDs consuming button presses.
- Replaces direct button-to-LED wiring with synchronised, debounced, edge-based control.

---
 rtl/pushbutton_toggle_pkg.sv | 18 +
 rtl/pushbutton_debounce.sv | 57 +++++
 rtl/pushbutton_toggle.sv | 64 ++++++
 tb/tb_pushbutton_toggle.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pushbutton_toggle_pkg.sv
// Shared constants and helpers for the pushbutton conditioning block.
package pushbutton_toggle_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 120000;
  localparam int unsigned CLK_HZ                  = 12_000_000;
  localparam logic        BTN_PRESSED             = 1'b1;

  // Counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 of the count itself is enough.
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  typedef struct packed {
    logic press;
    logic led;
  } btn_chan_t;

endpackage

// File: rtl/pushbutton_debounce.sv
// One button channel: two-flop synchroniser, persistence counter and registered press detect.
module pushbutton_debounce
  import pushbutton_toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable,
  output logic btn_stable_nxt,
  output logic btn_press
);

  localparam int unsigned     CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0_q, s1_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      s0_q     <= (btn_raw == BTN_PRESSED);
      s1_q     <= s0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  // Any cycle where the synchronised level agrees with the accepted one restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s1_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = stable_d & ~stable_q;
  end

  assign btn_stable     = stable_q;
  assign btn_stable_nxt = stable_d;
  assign btn_press      = press_q;

endmodule

// File: rtl/pushbutton_toggle.sv
// Two debounced pushbuttons, each giving a one-cycle press pulse and a toggled LED level.
module pushbutton_toggle
  import pushbutton_toggle_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic SW1,
  input  logic SW2,
  output logic PRESS1,
  output logic PRESS2,
  output logic LED0,
  output logic LED1
);

  logic [1:0]      sw_raw;
  logic [1:0]      stable;
  logic [1:0]      stable_nxt;
  logic [1:0]      press;
  logic [1:0]      led_q, led_d;
  btn_chan_t [1:0] chan;

  assign sw_raw = {SW2, SW1};

  for (genvar i = 0; i < 2; i++) begin : g_chan
    pushbutton_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (sw_raw[i]),
      .btn_stable    (stable[i]),
      .btn_stable_nxt(stable_nxt[i]),
      .btn_press     (press[i])
    );
  end

  // Toggle on the same edge the debouncer registers its press pulse.
  always_comb begin
    led_d = led_q ^ (stable_nxt & ~stable);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      chan[i].press = press[i];
      chan[i].led   = led_q[i];
    end
  end

  assign PRESS1 = chan[0].press;
  assign PRESS2 = chan[1].press;
  assign LED0   = chan[0].led;
  assign LED1   = chan[1].led;

endmodule

// File: tb/tb_pushbutton_toggle.sv
// Self-checking bench for pushbutton_toggle with a queue-based behavioural model.
module tb_pushbutton_toggle;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;
  logic sw1, sw2;
  logic press1, press2, led0, led1;

  int vectors = 0;
  int miscompares = 0;

  pushbutton_toggle #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .SW1   (sw1),
    .SW2   (sw2),
    .PRESS1(press1),
    .PRESS2(press2),
    .LED0  (led0),
    .LED1  (led1)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples history, per-channel accepted level, run length, outputs.
  bit [1:0] raw_q[$];
  bit       m_stable[2];
  bit       m_led[2];
  bit       m_press[2];
  int       m_run[2];
  int       npress[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    raw_q.delete();
    for (int c = 0; c < 2; c++) begin
      m_stable[c] = 1'b0;
      m_led[c]    = 1'b0;
      m_press[c]  = 1'b0;
      m_run[c]    = 0;
    end
  endtask

  // The accepted-level logic sees the raw input from two edges earlier.
  task automatic model_edge(input bit r1, input bit r2);
    bit [1:0] seen;
    raw_q.push_back({r2, r1});
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    seen = (raw_q.size() == 3) ? raw_q[0] : 2'b00;
    for (int c = 0; c < 2; c++) begin
      m_press[c] = 1'b0;
      if (seen[c] != m_stable[c]) begin
        m_run[c]++;
        if (m_run[c] == D) begin
          m_stable[c] = seen[c];
          m_run[c]    = 0;
          if (seen[c]) begin
            m_press[c] = 1'b1;
            m_led[c]   = ~m_led[c];
          end
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("PRESS1", press1, m_press[0]);
    check_val("PRESS2", press2, m_press[1]);
    check_val("LED0", led0, m_led[0]);
    check_val("LED1", led1, m_led[1]);
  endtask

  // One clock: model the edge with the inputs present at it, then compare 1 time unit later.
  task automatic step();
    bit r1, r2;
    r1 = sw1;
    r2 = sw2;
    @(posedge clk);
    model_edge(r1, r2);
    #1;
    if (press1 === 1'b1) npress[0]++;
    if (press2 === 1'b1) npress[1]++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int lat;
  int p0, p1;
  bit found;
  bit bounce_pat[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    rst = 1'b1;
    sw1 = 1'b0;
    sw2 = 1'b0;
    npress[0] = 0;
    npress[1] = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    run(8);

    // Clean press with latency measurement.
    sw1 = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!found && press1 === 1'b1) begin
        found = 1'b1;
        lat = i;
      end
    end
    check_val("press1_latency", lat, D + 2);
    check_val("press1_count_clean", npress[0], 1);
    sw1 = 1'b0;
    run(10);

    // Bounce, then held.
    p0 = npress[0];
    for (int i = 0; i < 6; i++) begin
      sw1 = bounce_pat[i];
      step();
    end
    run(12);
    check_val("press1_count_bounce", npress[0] - p0, 1);

    // Short glitch on SW2.
    p1 = npress[1];
    sw2 = 1'b1;
    run(3);
    sw2 = 1'b0;
    run(10);
    check_val("press2_count_glitch", npress[1] - p1, 0);

    // Hold and repeat.
    sw1 = 1'b0;
    run(10);
    p0 = npress[0];
    sw1 = 1'b1;
    run(50);
    sw1 = 1'b0;
    run(10);
    sw1 = 1'b1;
    run(10);
    check_val("press1_count_repeat", npress[0] - p0, 2);
    sw1 = 1'b0;
    run(10);

    // Simultaneous press on both buttons.
    sw1 = 1'b1;
    sw2 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!found && press1 === 1'b1) begin
        found = 1'b1;
        check_val("simul_press2", press2, 1'b1);
      end
    end
    check_val("simul_seen", found, 1'b1);

    // Release and reset asynchronously mid-debounce.
    sw1 = 1'b0;
    sw2 = 1'b0;
    run(4);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    check_val("rst_async_PRESS1", press1, 1'b0);
    check_val("rst_async_PRESS2", press2, 1'b0);
    check_val("rst_async_LED0", led0, 1'b0);
    check_val("rst_async_LED1", led1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = npress[0];
    p1 = npress[1];
    run(12);
    check_val("post_rst_quiet", (npress[0] - p0) + (npress[1] - p1), 0);

    // Randomised activity.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) sw1 = ~sw1;
      if ($urandom_range(0, 7) == 0) sw2 = ~sw2;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
